// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the 5-stage MIPS hazard controller: FSM states,
// forwarding select codes and the hard-wired zero register.
package mips_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_LU    = 2'd1,
    ST_MWAIT = 2'd2
  } state_t;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_MEM = 2'b10;
  localparam logic [1:0] FWD_WB  = 2'b01;

  localparam logic [4:0] REG_ZERO = 5'd0;

  localparam int WAIT_W = 4;

endpackage

// File: rtl/forward_unit.sv
// EX-stage operand forwarding: picks EX/MEM result over MEM/WB data over
// the register file. $0 is never forwarded.
module forward_unit
  import mips_ctrl_pkg::*;
(
  input  logic [4:0] ex_rs,
  input  logic [4:0] ex_rt,
  input  logic [4:0] mem_wreg,
  input  logic       mem_reg_write,
  input  logic [4:0] wb_wreg,
  input  logic       wb_reg_write,
  output logic [1:0] fwd_a,
  output logic [1:0] fwd_b
);

  function automatic logic [1:0] fwd_sel(
    input logic [4:0] src,
    input logic [4:0] m_wreg,
    input logic       m_we,
    input logic [4:0] w_wreg,
    input logic       w_we
  );
    if (m_we && (m_wreg != REG_ZERO) && (m_wreg == src)) return FWD_MEM;
    if (w_we && (w_wreg != REG_ZERO) && (w_wreg == src)) return FWD_WB;
    return FWD_RF;
  endfunction

  assign fwd_a = fwd_sel(ex_rs, mem_wreg, mem_reg_write, wb_wreg, wb_reg_write);
  assign fwd_b = fwd_sel(ex_rt, mem_wreg, mem_reg_write, wb_wreg, wb_reg_write);

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard/sequencing controller for the 5-stage MIPS pipeline: load-use
// bubbles, multi-cycle MEM freeze, branch flushes and event counters.
module pipeline_hazard_ctrl
  import mips_ctrl_pkg::*;
#(
  parameter int MEM_LAT = 1,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic [4:0]       ex_rs,
  input  logic [4:0]       ex_rt,
  input  logic [4:0]       ex_wreg,
  input  logic             ex_mem_read,
  input  logic [4:0]       mem_wreg,
  input  logic             mem_reg_write,
  input  logic             mem_mem_read,
  input  logic [4:0]       wb_wreg,
  input  logic             wb_reg_write,
  input  logic             pc_src,
  output logic             pc_write,
  output logic             ifid_write,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic             exmem_flush,
  output logic             exmem_write,
  output logic [1:0]       fwd_a,
  output logic [1:0]       fwd_b,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam bit MULTI = (MEM_LAT > 1);
  localparam bit LONG  = (MEM_LAT > 2);
  localparam logic [WAIT_W-1:0] WAIT_INIT = WAIT_W'(LONG ? MEM_LAT - 2 : 0);

  state_t            state, state_nxt;
  logic [WAIT_W-1:0] wait_ctr, wait_nxt;
  logic              mem_done, mem_done_nxt;
  logic              load_use;
  logic              flush_evt;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  forward_unit u_fwd (
    .ex_rs         (ex_rs),
    .ex_rt         (ex_rt),
    .mem_wreg      (mem_wreg),
    .mem_reg_write (mem_reg_write),
    .wb_wreg       (wb_wreg),
    .wb_reg_write  (wb_reg_write),
    .fwd_a         (fwd_a),
    .fwd_b         (fwd_b)
  );

  assign load_use = ex_mem_read && (ex_wreg != REG_ZERO) &&
                    ((ex_wreg == id_rs) || (ex_wreg == id_rt));

  // The load stays in EX/MEM for one RUN cycle after the freeze ends;
  // mem_done keeps that cycle from starting a second freeze.
  always_comb begin
    state_nxt    = state;
    wait_nxt     = wait_ctr;
    mem_done_nxt = 1'b0;
    pc_write     = 1'b1;
    ifid_write   = 1'b1;
    exmem_write  = 1'b1;
    ifid_flush   = 1'b0;
    idex_flush   = 1'b0;
    exmem_flush  = 1'b0;
    flush_evt    = 1'b0;
    unique case (state)
      ST_RUN: begin
        if (pc_src) begin
          ifid_flush  = 1'b1;
          idex_flush  = 1'b1;
          exmem_flush = 1'b1;
          flush_evt   = 1'b1;
        end else if (MULTI && mem_mem_read && !mem_done) begin
          pc_write    = 1'b0;
          ifid_write  = 1'b0;
          exmem_write = 1'b0;
          if (LONG) begin
            wait_nxt  = WAIT_INIT;
            state_nxt = ST_MWAIT;
          end else begin
            mem_done_nxt = 1'b1;
          end
        end else if (load_use) begin
          pc_write   = 1'b0;
          ifid_write = 1'b0;
          idex_flush = 1'b1;
          state_nxt  = ST_LU;
        end
      end
      ST_LU: state_nxt = ST_RUN;
      ST_MWAIT: begin
        // wait_ctr counts frozen cycles still owed, including this one.
        pc_write    = 1'b0;
        ifid_write  = 1'b0;
        exmem_write = 1'b0;
        if (wait_ctr <= WAIT_W'(1)) begin
          state_nxt    = ST_RUN;
          mem_done_nxt = 1'b1;
        end else begin
          wait_nxt = wait_ctr - 1'b1;
        end
      end
      default: state_nxt = ST_RUN;
    endcase
    if (reset) begin
      pc_write    = 1'b1;
      ifid_write  = 1'b1;
      exmem_write = 1'b1;
      ifid_flush  = 1'b0;
      idex_flush  = 1'b0;
      exmem_flush = 1'b0;
      flush_evt   = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= ST_RUN;
      wait_ctr  <= '0;
      mem_done  <= 1'b0;
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      state    <= state_nxt;
      wait_ctr <= wait_nxt;
      mem_done <= mem_done_nxt;
      if (!pc_write) stall_cnt <= sat_inc(stall_cnt);
      if (flush_evt) flush_cnt <= sat_inc(flush_cnt);
    end
  end

endmodule
